// File: rtl/fir_mac_sched_pkg.sv
// Shared types and default constants for the FIR MAC scheduler.
package fir_mac_sched_pkg;

   localparam int FIR_NUM_CH   = 2;
   localparam int FIR_NUM_TAPS = 32;
   localparam int FIR_MAC_LAT  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sched_state_t;

   // Index width for n items, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fir_mac_sched_if.sv
// Channel handshake and shared-MAC control bundle.
// master = scheduler side, slave = channel/datapath side.
interface fir_mac_sched_if
   import fir_mac_sched_pkg::*;
#(
   parameter int NUM_CH   = FIR_NUM_CH,
   parameter int NUM_TAPS = FIR_NUM_TAPS
) ();

   localparam int CH_W  = clog2_min1(NUM_CH);
   localparam int TAP_W = clog2_min1(NUM_TAPS);

   logic [NUM_CH-1:0] ch_req;
   logic [NUM_CH-1:0] ch_gnt;
   logic [NUM_CH-1:0] ch_done;
   logic [CH_W-1:0]   ch_sel;
   logic [TAP_W-1:0]  tap_idx;
   logic              mac_en;
   logic              mac_clr;
   logic              mac_stall;
   logic              busy;

   modport master (
      input  ch_req, mac_stall,
      output ch_gnt, ch_done, ch_sel, tap_idx, mac_en, mac_clr, busy
   );

   modport slave (
      output ch_req, mac_stall,
      input  ch_gnt, ch_done, ch_sel, tap_idx, mac_en, mac_clr, busy
   );

endinterface

// File: rtl/fir_mac_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester after the last grant.
module rr_arbiter
   import fir_mac_sched_pkg::*;
#(
   parameter int NUM_CH = FIR_NUM_CH,
   parameter int CH_W   = clog2_min1(NUM_CH)
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [CH_W-1:0]   i_last,
   output logic [NUM_CH-1:0] o_gnt,
   output logic [CH_W-1:0]   o_idx,
   output logic              o_valid
);

   int               w_c;
   logic [CH_W-1:0]  w_ci;

   // Scan channels in rotation order starting just past i_last.
   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_c     = 0;
      w_ci    = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         w_c  = (int'(i_last) + i) % NUM_CH;
         w_ci = CH_W'(w_c);
         if (!o_valid && i_req[w_ci]) begin
            o_valid     = 1'b1;
            o_idx       = w_ci;
            o_gnt[w_ci] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fir_mac_sched.sv
// Time-shares one FIR MAC between NUM_CH channels, one tap burst at a time.
//
// state | meaning
// IDLE  | waiting for a request; arbiter picks the next channel
// RUN   | stepping tap_idx through 0..NUM_TAPS-1, frozen by mac_stall
// DRAIN | waiting MAC_LAT cycles for the MAC pipeline to empty
// DONE  | one-cycle ch_done pulse, round-robin pointer advances
module fir_mac_sched
   import fir_mac_sched_pkg::*;
#(
   parameter int NUM_CH   = FIR_NUM_CH,
   parameter int NUM_TAPS = FIR_NUM_TAPS,
   parameter int MAC_LAT  = FIR_MAC_LAT
) (
   input  logic            i_clk,
   input  logic            i_rst,
   fir_mac_sched_if.master bus
);

   localparam int CH_W  = clog2_min1(NUM_CH);
   localparam int TAP_W = clog2_min1(NUM_TAPS);
   localparam int CNT_W = clog2_min1(MAC_LAT);
   localparam logic [TAP_W-1:0] LAST_TAP   = TAP_W'(NUM_TAPS - 1);
   // Drain timer counts down to zero, so it is loaded with MAC_LAT-1.
   localparam logic [CNT_W-1:0] DRAIN_LOAD = (MAC_LAT > 0) ? CNT_W'(MAC_LAT - 1) : '0;

   sched_state_t       r_state;
   sched_state_t       w_state_nxt;
   logic [TAP_W-1:0]   r_tap;
   logic [CH_W-1:0]    r_sel;
   logic [CH_W-1:0]    r_last;
   logic [NUM_CH-1:0]  r_gnt;
   logic [CNT_W-1:0]   r_cnt;

   logic [NUM_CH-1:0]  w_arb_gnt;
   logic [CH_W-1:0]    w_arb_idx;
   logic               w_arb_valid;
   logic               w_mac_en;
   logic               w_last_tap;
   logic               w_drain_tc;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_arb (
      .i_req   (bus.ch_req),
      .i_last  (r_last),
      .o_gnt   (w_arb_gnt),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_valid)
   );

   assign w_last_tap = (r_tap == LAST_TAP);
   assign w_drain_tc = (r_cnt == '0);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_arb_valid) w_state_nxt = RUN;
         RUN:     if (w_mac_en && w_last_tap) w_state_nxt = (MAC_LAT == 0) ? DONE : DRAIN;
         DRAIN:   if (w_drain_tc) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output decode; mac_en follows stall combinationally so a stalled tap is never accumulated.
   always_comb begin
      w_mac_en    = (r_state == RUN) && !bus.mac_stall;
      bus.mac_en  = w_mac_en;
      bus.mac_clr = w_mac_en && (r_tap == '0);
      bus.ch_done = (r_state == DONE) ? r_gnt : '0;
      bus.ch_gnt  = r_gnt;
      bus.ch_sel  = r_sel;
      bus.tap_idx = r_tap;
      bus.busy    = (r_state != IDLE);
   end

   // Grant latch, tap counter, drain timer and round-robin pointer.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tap  <= '0;
         r_sel  <= '0;
         r_gnt  <= '0;
         r_cnt  <= '0;
         r_last <= CH_W'(NUM_CH - 1);
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_arb_valid) begin
                  r_sel <= w_arb_idx;
                  r_gnt <= w_arb_gnt;
                  r_tap <= '0;
               end
            end
            RUN: begin
               if (w_mac_en) begin
                  r_tap <= w_last_tap ? '0 : r_tap + TAP_W'(1);
                  if (w_last_tap) r_cnt <= DRAIN_LOAD;
               end
            end
            DRAIN: begin
               if (!w_drain_tc) r_cnt <= r_cnt - CNT_W'(1);
            end
            DONE: begin
               r_last <= r_sel;
               r_gnt  <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Bench for fir_mac_sched: scripted plan scenarios plus randomized bursts
// checked against a transaction-level round-robin/timing model.
module tb_fir_mac_sched;

   localparam int NCH = 2;
   localparam int NT  = 32;
   localparam int LAT = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           sel_b = 1'b0;
   logic [NCH-1:0] req = '0;
   logic           stall = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;
   int m_last = NCH - 1;

   fir_mac_sched_if #(.NUM_CH(NCH), .NUM_TAPS(NT)) bus_a ();
   fir_mac_sched_if #(.NUM_CH(NCH), .NUM_TAPS(NT)) bus_b ();

   assign bus_a.ch_req    = sel_b ? '0 : req;
   assign bus_a.mac_stall = sel_b ? 1'b0 : stall;
   assign bus_b.ch_req    = sel_b ? req : '0;
   assign bus_b.mac_stall = sel_b ? stall : 1'b0;

   logic [NCH-1:0] o_gnt, o_done;
   logic           o_sel, o_en, o_clr, o_busy;
   logic [4:0]     o_tap;

   assign o_gnt  = sel_b ? bus_b.ch_gnt  : bus_a.ch_gnt;
   assign o_done = sel_b ? bus_b.ch_done : bus_a.ch_done;
   assign o_sel  = sel_b ? bus_b.ch_sel  : bus_a.ch_sel;
   assign o_tap  = sel_b ? bus_b.tap_idx : bus_a.tap_idx;
   assign o_en   = sel_b ? bus_b.mac_en  : bus_a.mac_en;
   assign o_clr  = sel_b ? bus_b.mac_clr : bus_a.mac_clr;
   assign o_busy = sel_b ? bus_b.busy    : bus_a.busy;

   fir_mac_sched #(.NUM_CH(NCH), .NUM_TAPS(NT), .MAC_LAT(LAT)) u_dut_a (
      .i_clk (clk),
      .i_rst (rst | sel_b),
      .bus   (bus_a)
   );

   fir_mac_sched #(.NUM_CH(NCH), .NUM_TAPS(NT), .MAC_LAT(0)) u_dut_b (
      .i_clk (clk),
      .i_rst (rst | ~sel_b),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference arbitration: first requester strictly after the last served channel.
   function automatic int model_pick(input logic [NCH-1:0] r, input int last);
      for (int i = 1; i <= NCH; i++) begin
         if (r[(last + i) % NCH]) return (last + i) % NCH;
      end
      return -1;
   endfunction

   function automatic logic [31:0] oh(input int ch);
      return 32'(1) << ch;
   endfunction

   task automatic check_quiet(input string tag);
      chk({tag, "_gnt"},  32'(o_gnt),  0);
      chk({tag, "_done"}, 32'(o_done), 0);
      chk({tag, "_busy"}, 32'(o_busy), 0);
      chk({tag, "_en"},   32'(o_en),   0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      chk("rst_gnt",  32'(o_gnt),  0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_sel",  32'(o_sel),  0);
      chk("rst_tap",  32'(o_tap),  0);
      chk("rst_en",   32'(o_en),   0);
      chk("rst_clr",  32'(o_clr),  0);
      chk("rst_busy", 32'(o_busy), 0);
      rst = 1'b0;
      m_last = NCH - 1;
   endtask

   task automatic idle_watch(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check_quiet("idle");
      end
   endtask

   // Caller has req applied during an IDLE cycle (cycle 0). mode: 0 no stall,
   // 1 random stall, 2 three stalls on tap 0 and two on the last tap.
   task automatic run_burst(input int exp_ch, input int mode, input int drop_tap,
                            input int rst_tap, output int t_done);
      int lat, acc, t, nstall, st0, stl, en_cnt;
      logic s;
      bit   got_done;
      lat = sel_b ? 0 : LAT;
      acc = 0; t = 0; nstall = 0; st0 = 3; stl = 2; en_cnt = 0;
      t_done = -1;
      step();
      t = 1;
      chk("gnt_first", 32'(o_gnt), oh(exp_ch));
      chk("sel",       32'(o_sel), 32'(exp_ch));
      chk("busy_run",  32'(o_busy), 1);
      for (int k = 0; k < 400; k++) begin
         case (mode)
            1: s = ($urandom_range(0, 3) == 0);
            2: begin
               s = 1'b0;
               if (acc == 0 && st0 > 0) begin s = 1'b1; st0--; end
               else if (acc == NT-1 && stl > 0) begin s = 1'b1; stl--; end
            end
            default: s = 1'b0;
         endcase
         stall = s;
         #1;
         chk("tap",        32'(o_tap), 32'(acc));
         chk("mac_en",     32'(o_en),  32'(!s));
         chk("mac_clr",    32'(o_clr), 32'(!s && acc == 0));
         chk("gnt_run",    32'(o_gnt), oh(exp_ch));
         chk("gnt_onehot", 32'($onehot0(o_gnt)), 1);
         chk("done_run",   32'(o_done), 0);
         if (o_en) en_cnt++;
         if (acc == drop_tap) req = req & ~(NCH'(1) << exp_ch);
         if (acc == rst_tap) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            stall = 1'b0;
            #1;
            check_quiet("rst_mid");
            chk("rst_mid_tap", 32'(o_tap), 0);
            chk("rst_mid_sel", 32'(o_sel), 0);
            chk("rst_mid_clr", 32'(o_clr), 0);
            m_last = NCH - 1;
            return;
         end
         if (!s) acc++; else nstall++;
         if (acc == NT) break;
         step();
         t++;
      end
      if (acc != NT) begin
         chk("burst_timeout", 32'(acc), 32'(NT));
         return;
      end
      got_done = 1'b0;
      for (int d = 0; d < lat + 8; d++) begin
         stall = 1'b0;
         step();
         t++;
         stall = 1'($urandom_range(0, 1));
         #1;
         if (o_done != '0) begin
            got_done = 1'b1;
            break;
         end
         chk("drain_en",   32'(o_en),   0);
         chk("drain_clr",  32'(o_clr),  0);
         chk("drain_busy", 32'(o_busy), 1);
         chk("drain_gnt",  32'(o_gnt),  oh(exp_ch));
      end
      stall = 1'b0;
      if (!got_done) begin
         chk("done_timeout", 0, 1);
         return;
      end
      chk("done_val",  32'(o_done), oh(exp_ch));
      chk("done_cyc",  32'(t), 32'(1 + NT + nstall + lat));
      chk("done_gnt",  32'(o_gnt), oh(exp_ch));
      chk("done_en",   32'(o_en), 0);
      chk("en_count",  32'(en_cnt), 32'(NT));
      t_done = t;
      m_last = exp_ch;
      step();
      check_quiet("post_done");
   endtask

   initial begin
      int td, exp_ch, drop;
      logic [NCH-1:0] r;

      do_reset();

      // Single request on ch0.
      req = 2'b01;
      run_burst(model_pick(req, m_last), 0, -1, -1, td);
      chk("single_done_cyc", 32'(td), 35);
      req = 2'b00;
      idle_watch(3);

      // Both channels requesting: strict alternation from ch0.
      do_reset();
      req = 2'b11;
      for (int b = 0; b < 4; b++) begin
         exp_ch = model_pick(req, m_last);
         chk("alt_order", 32'(exp_ch), 32'(b % 2));
         run_burst(exp_ch, 0, -1, -1, td);
      end
      req = 2'b00;
      idle_watch(2);

      // Stalls on the first and last tap.
      req = 2'b01;
      run_burst(model_pick(req, m_last), 2, -1, -1, td);
      chk("stall_done_cyc", 32'(td), 40);
      req = 2'b00;
      idle_watch(2);

      // Request withdrawn mid-burst.
      do_reset();
      req = 2'b01;
      run_burst(model_pick(req, m_last), 0, 10, -1, td);
      chk("drop_req_now", 32'(req), 0);
      idle_watch(40);

      // Reset mid-burst, then both request: ch0 must win.
      req = 2'b01;
      run_burst(model_pick(req, m_last), 0, -1, 15, td);
      req = 2'b00;
      idle_watch(40);
      req = 2'b11;
      exp_ch = model_pick(req, m_last);
      chk("post_rst_pick", 32'(exp_ch), 0);
      run_burst(exp_ch, 0, -1, -1, td);
      req = 2'b00;
      idle_watch(2);

      // Randomized requests, drops and stalls.
      for (int it = 0; it < 16; it++) begin
         r = NCH'($urandom_range(1, (1 << NCH) - 1));
         req = r;
         drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NT-1)) : -1;
         exp_ch = model_pick(req, m_last);
         run_burst(exp_ch, 1, drop, -1, td);
         if ($urandom_range(0, 3) == 0) begin
            req = '0;
            idle_watch(int'($urandom_range(1, 4)));
         end
      end
      req = '0;
      idle_watch(2);

      // MAC_LAT = 0 instance.
      sel_b = 1'b1;
      do_reset();
      req = 2'b01;
      run_burst(model_pick(req, m_last), 0, -1, -1, td);
      chk("lat0_done_cyc", 32'(td), 33);
      req = 2'b11;
      run_burst(model_pick(req, m_last), 1, -1, -1, td);
      req = '0;
      idle_watch(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/fir_mac_sched.md
Name: fir_mac_sched

Overview:
- Round-robin scheduler that time-shares one FIR multiply-accumulate datapath between NUM_CH filter channels (e.g. I and Q in the radio chain).
- Grants the MAC to one channel at a time and sequences a full NUM_TAPS burst of tap indices.
- Waits MAC_LAT cycles for the MAC pipeline to drain, then pulses a per-channel done.
- Sits between the per-channel sample/decimation logic and the shared MAC plus coefficient ROM.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8).
- NUM_TAPS, 32, taps per output sample.
- MAC_LAT, 2, MAC pipeline depth in cycles after the last tap (0 allowed).
- TAP_W, $clog2(NUM_TAPS), tap index width.
- CH_W, max(1,$clog2(NUM_CH)), channel index width.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- ch_req, in, NUM_CH, per-channel request; level, sampled only in IDLE.
- ch_gnt, out, NUM_CH, one-hot grant; held from RUN through DONE.
- ch_done, out, NUM_CH, one-cycle pulse on the granted channel when its result is valid at the MAC output.
- ch_sel, out, CH_W, index of the granted channel; drives the sample-buffer/MAC input mux.
- tap_idx, out, TAP_W, current tap; addresses the coefficient ROM and the sample delay line.
- mac_en, out, 1, MAC accumulate enable.
- mac_clr, out, 1, MAC load-instead-of-accumulate on the first tap.
- mac_stall, in, 1, datapath not ready; freezes tap sequencing.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- States: IDLE, RUN, DRAIN, DONE. All state, the counter, the channel register and the round-robin pointer are registered.
- Reset values: state=IDLE, ch_gnt=0, ch_done=0, ch_sel=0, tap_idx=0, mac_en=0, mac_clr=0, busy=0, rr pointer set so ch0 has highest priority.
- IDLE: if any ch_req is high, pick the first requester at or after (last_granted+1) mod NUM_CH.
  - Latch ch_sel and ch_gnt, set tap_idx=0, go to RUN.
  - Grant is visible the cycle after the request is sampled.
- RUN: mac_en = !mac_stall; mac_clr = mac_en && tap_idx==0.
  - tap_idx increments only when mac_en=1.
  - When tap_idx==NUM_TAPS-1 and mac_en=1: go to DRAIN with a counter of MAC_LAT, or go directly to DONE if MAC_LAT=0.
- DRAIN: mac_en=0, mac_clr=0. Count down MAC_LAT cycles, then go to DONE. mac_stall is ignored.
- DONE: ch_done[ch_sel]=1 for exactly one cycle. Update rr pointer to ch_sel. Next state is IDLE, where ch_gnt clears.
- Latency with no stalls: request sampled in IDLE at cycle 0 → RUN cycles 1..NUM_TAPS → DONE at cycle NUM_TAPS+MAC_LAT+1 (35 with defaults).
  - Minimum spacing between successive grants is NUM_TAPS+MAC_LAT+2 cycles.
- Boundary conditions:
  - mac_stall on tap 0: mac_clr is deferred until the tap is accepted.
  - mac_stall on the last tap: holds RUN.
  - ch_req dropped mid-burst: ignored; the burst completes and done still pulses.
  - Request from the granted channel still high at DONE: that channel is re-eligible, but other pending channels win first.
  - Simultaneous requests: strict rotation, no starvation.
  - Reset mid-burst: immediately returns to reset values; no done pulse; the partial MAC result is discarded by the datapath.
  - Only one ch_gnt bit may ever be set; ch_done is never set outside DONE.

Decomposition:
- radio_const_pkg gains:
  - sched_state_t enum {IDLE,RUN,DRAIN,DONE};
  - constants FIR_NUM_CH and FIR_MAC_LAT.
- One sub-module, rr_arbiter (parameter NUM_CH):
  - combinational pick from req and pointer;
  - outputs a one-hot grant and an index.
- Sequencing FSM and counters stay in fir_mac_sched.

Test Plan:
1. Single request: ch_req=01 held at cycle 0.
   - ch_gnt=01 at cycle 1.
   - tap_idx 0..31 on cycles 1..32; mac_clr only at cycle 1.
   - ch_done=01 at cycle 35; busy low at cycle 36.
2. Simultaneous requests: ch_req=11 held.
   - Grants alternate 01,10,01,10.
   - Each done pulses once per burst; grant starts are 36 cycles apart.
3. Stalls: assert mac_stall at tap 0 for 3 cycles and at tap 31 for 2 cycles.
   - tap_idx holds during stalls; mac_clr rises only when the stall releases.
   - mac_en count equals 32; done is delayed by 5 cycles, to cycle 40.
4. Request withdrawn: drop ch_req[0] at tap 10.
   - Burst still completes; ch_done=01 pulses.
   - No new grant while ch_req=00.
5. Reset mid-burst: assert rst at tap 15 for 1 cycle.
   - All outputs return to 0 the next cycle; no ch_done pulse.
   - A subsequent ch_req=11 grants ch0 first.
6. MAC_LAT=0 build: single request.
   - DONE at cycle 33; DRAIN is never entered.
